// File: rtl/hazard_unit.sv
// Pipeline hazard unit: tracks EX/MEM/WB producers, raises stall/flush controls and registers forwarding selects.
// Define FORWARD_EN to stall only on load-use and forward from EX/MEM; otherwise every RAW hazard stalls.
module hazard_unit (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        id_valid_i,
   input  logic [4:0]  id_rs_i,
   input  logic [4:0]  id_rt_i,
   input  logic        id_uses_rs_i,
   input  logic        id_uses_rt_i,
   input  logic [4:0]  id_rd_i,
   input  logic        id_regwrite_i,
   input  logic        id_memread_i,
   input  logic        branch_taken_i,
   output logic        pc_write_o,
   output logic        ifid_write_o,
   output logic        ifid_flush_o,
   output logic        idex_bubble_o,
   output logic [1:0]  fwd_a_o,
   output logic [1:0]  fwd_b_o,
   output logic [1:0]  state_o,
   output logic [15:0] stall_count_o
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regwrite;
      logic       memread;
   } slot_t;

   typedef enum logic [1:0] {
      ACT_RUN   = 2'b00,
      ACT_STALL = 2'b01,
      ACT_FLUSH = 2'b10
   } action_t;

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_EXMEM   = 2'b10;
   localparam logic [1:0] FWD_MEMWB   = 2'b01;

   slot_t       r_ex;
   slot_t       r_mem;
   slot_t       r_wb;
   logic [1:0]  r_fwdA;
   logic [1:0]  r_fwdB;
   action_t     r_state;
   logic [15:0] r_stallCount;

   slot_t       w_idEntry;
   logic        w_exProd;
   logic        w_memProd;
   logic        w_rsMatchEx;
   logic        w_rtMatchEx;
   logic        w_rsMatchMem;
   logic        w_rtMatchMem;
   logic        w_stall;
   logic        w_issue;
   action_t     w_action;
   logic [1:0]  w_fwdANext;
   logic [1:0]  w_fwdBNext;

   // Register 0 is hardwired, so a slot writing it is never a producer.
   function automatic logic isProducer(input slot_t s);
      return s.valid && s.regwrite && (s.rd != 5'd0);
   endfunction

   assign w_idEntry = '{valid: id_valid_i, rd: id_rd_i, regwrite: id_regwrite_i, memread: id_memread_i};

   assign w_exProd     = isProducer(r_ex);
   assign w_memProd    = isProducer(r_mem);
   assign w_rsMatchEx  = id_valid_i && id_uses_rs_i && w_exProd  && (id_rs_i == r_ex.rd);
   assign w_rtMatchEx  = id_valid_i && id_uses_rt_i && w_exProd  && (id_rt_i == r_ex.rd);
   assign w_rsMatchMem = id_valid_i && id_uses_rs_i && w_memProd && (id_rs_i == r_mem.rd);
   assign w_rtMatchMem = id_valid_i && id_uses_rt_i && w_memProd && (id_rt_i == r_mem.rd);

`ifdef FORWARD_EN
   assign w_stall = r_ex.memread && (w_rsMatchEx || w_rtMatchEx);

   // EX/MEM result is younger than MEM/WB, so it wins when both match.
   always_comb begin
      w_fwdANext = FWD_REGFILE;
      w_fwdBNext = FWD_REGFILE;
      if (w_issue) begin
         if (w_rsMatchEx)       w_fwdANext = FWD_EXMEM;
         else if (w_rsMatchMem) w_fwdANext = FWD_MEMWB;
         if (w_rtMatchEx)       w_fwdBNext = FWD_EXMEM;
         else if (w_rtMatchMem) w_fwdBNext = FWD_MEMWB;
      end
   end
`else
   assign w_stall    = w_rsMatchEx || w_rtMatchEx || w_rsMatchMem || w_rtMatchMem;
   assign w_fwdANext = FWD_REGFILE;
   assign w_fwdBNext = FWD_REGFILE;
`endif

   // A taken branch discards the ID instruction, so it overrides any stall.
   always_comb begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      w_issue       = 1'b0;
      w_action      = ACT_RUN;
      if (rst_i) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
      end else if (branch_taken_i) begin
         ifid_flush_o  = 1'b1;
         idex_bubble_o = 1'b1;
         w_action      = ACT_FLUSH;
      end else if (w_stall) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
         w_action      = ACT_STALL;
      end else begin
         w_issue = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ex         <= '0;
         r_mem        <= '0;
         r_wb         <= '0;
         r_fwdA       <= FWD_REGFILE;
         r_fwdB       <= FWD_REGFILE;
         r_state      <= ACT_RUN;
         r_stallCount <= 16'd0;
      end else begin
         r_wb    <= r_mem;
         r_mem   <= r_ex;
         r_ex    <= w_issue ? w_idEntry : slot_t'('0);
         r_fwdA  <= w_fwdANext;
         r_fwdB  <= w_fwdBNext;
         r_state <= w_action;
         if (w_action == ACT_STALL && r_stallCount != 16'hFFFF)
            r_stallCount <= r_stallCount + 16'd1;
      end
   end

   assign fwd_a_o       = r_fwdA;
   assign fwd_b_o       = r_fwdB;
   assign state_o       = r_state;
   assign stall_count_o = r_stallCount;

endmodule
